stage_sequencer: RTL and testbench

- Parametrised pipeline-control successor to the phase counter.
- Replaces the five rotating phase clocks with single-clock stage enables plus per-stage valid bits for a true N-stage pipeline.
- Adds run/step/pause control from the debounced `exec` button, interlock stall, branch flush and halt drain.
- Sits beside the PC, IR and pipeline registers in the processor top level; every pipeline register loads on its `stage_en` bit.

---
 rtl/stage_seq_pkg.sv | 18 +
 rtl/stage_valid_pipe.sv | 65 ++++++
 rtl/stage_sequencer.sv | 158 +++++++++++++++
 tb/tb_stage_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stage_seq_pkg.sv
// Shared definitions for the stage sequencer: FSM state encoding and default
// pipeline geometry used by stage_sequencer and stage_valid_pipe.
package stage_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam int DEF_NSTAGE      = 5;
    localparam int DEF_STALL_STAGE = 1;
    localparam int DEF_FLUSH_STAGE = 2;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/stage_valid_pipe.sv
// Per-stage valid shift register: stalls hold the front stages and insert a
// bubble behind them; kill bits clear the next-cycle valid of selected stages.
module stage_valid_pipe
    import stage_seq_pkg::*;
#(
    parameter int NSTAGE      = DEF_NSTAGE,
    parameter int STALL_STAGE = DEF_STALL_STAGE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic [NSTAGE-1:0] kill,
    output logic [NSTAGE-1:0] shift_en,
    output logic [NSTAGE-1:0] valid
);

    logic [NSTAGE-1:0] valid_q;
    logic [NSTAGE-1:0] valid_d;

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
            localparam bit HOLD   = (gi <= STALL_STAGE);
            localparam bit BUBBLE = (gi == STALL_STAGE + 1);

            logic prev_valid;
            logic stage_d;

            if (gi == 0) begin : g_head
                assign prev_valid = in_valid;
            end else begin : g_body
                assign prev_valid = valid_q[gi-1];
            end

            // Kill wins over everything; the bubble replaces the held stage's copy.
            always_comb begin
                stage_d = prev_valid;
                if (stall && HOLD) begin
                    stage_d = valid_q[gi];
                end
                if (stall && BUBBLE) begin
                    stage_d = 1'b0;
                end
                if (kill[gi]) begin
                    stage_d = 1'b0;
                end
            end

            assign valid_d[gi]  = stage_d;
            assign shift_en[gi] = !(stall && HOLD);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;

endmodule

// File: rtl/stage_sequencer.sv
// Single-clock pipeline controller: run/step/pause FSM, stall/flush/halt
// qualification and stage enables. Optional counters under STAGE_SEQ_PERF_EN.
module stage_sequencer
    import stage_seq_pkg::*;
#(
    parameter int NSTAGE      = DEF_NSTAGE,
    parameter int STALL_STAGE = DEF_STALL_STAGE,
    parameter int FLUSH_STAGE = DEF_FLUSH_STAGE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exec,
    input  logic              step_mode,
    input  logic              stall_req,
    input  logic              flush_req,
    input  logic              halt_req,
    output logic              fetch_en,
    output logic [NSTAGE-1:0] stage_en,
    output logic [NSTAGE-1:0] stage_valid,
    output logic              retire,
    output logic [2:0]        state,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t state_q;
    state_t state_d;
    logic   halt_q;
    logic   halt_d;

    logic [NSTAGE-1:0] valid;
    logic [NSTAGE-1:0] shift_en;
    logic [NSTAGE-1:0] kill;
    logic              flush_eff;
    logic              halt_eff;
    logic              stall_eff;

    // Flush > halt > stall; a request from an empty stage is ignored.
    assign flush_eff = flush_req & valid[FLUSH_STAGE];
    assign halt_eff  = halt_req  & valid[STALL_STAGE] & ~flush_eff;
    assign stall_eff = stall_req & valid[STALL_STAGE] & ~flush_eff & ~halt_eff;

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_kill
            localparam bit IN_FLUSH = (gi <= FLUSH_STAGE);
            localparam bit IN_HALT  = (gi <= STALL_STAGE);
            assign kill[gi] = (flush_eff & IN_FLUSH) | (halt_eff & IN_HALT);
        end
    endgenerate

    stage_valid_pipe #(
        .NSTAGE      (NSTAGE),
        .STALL_STAGE (STALL_STAGE)
    ) u_valid_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (fetch_en),
        .stall    (stall_eff),
        .kill     (kill),
        .shift_en (shift_en),
        .valid    (valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        if (busy && halt_eff) begin
            halt_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (exec) begin
                    state_d = step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN: begin
                if (exec || halt_eff) begin
                    state_d = ST_DRAIN;
                end
            end
            // STEP lasts until its single fetch issues (or a halt arrives).
            ST_STEP: begin
                if (halt_eff || fetch_en) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (valid == '0) begin
                    state_d = halt_q ? ST_HALTED : ST_IDLE;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
        halted   = (state_q == ST_HALTED);
        fetch_en = ((state_q == ST_RUN) || (state_q == ST_STEP))
                   & ~stall_eff & ~flush_eff & ~halt_eff;
        // The pipeline is empty outside busy states, so enables idle low there.
        stage_en = busy ? shift_en : '0;
    end

    assign stage_valid = valid;
    assign retire      = valid[NSTAGE-1];
    assign state       = state_q;

`ifdef STAGE_SEQ_PERF_EN
    logic [CNT_W-1:0] retire_cnt_q;
    logic [CNT_W-1:0] retire_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (retire) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
        if (stall_eff) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`else
    assign retire_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed, table-driven bench for stage_sequencer (NSTAGE=5, STALL=1, FLUSH=2),
// with hand-written sequences for asynchronous reset and counter wrap.
module tb_stage_sequencer;

    localparam int N = 5;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         exec = 1'b0;
    logic         step_mode = 1'b0;
    logic         stall_req = 1'b0;
    logic         flush_req = 1'b0;
    logic         halt_req = 1'b0;
    logic         fetch_en;
    logic [N-1:0] stage_en;
    logic [N-1:0] stage_valid;
    logic         retire;
    logic [2:0]   state;
    logic         busy;
    logic         halted;
    logic [W-1:0] retire_cnt;
    logic [W-1:0] stall_cnt;

    stage_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exec        (exec),
        .step_mode   (step_mode),
        .stall_req   (stall_req),
        .flush_req   (flush_req),
        .halt_req    (halt_req),
        .fetch_en    (fetch_en),
        .stage_en    (stage_en),
        .stage_valid (stage_valid),
        .retire      (retire),
        .state       (state),
        .busy        (busy),
        .halted      (halted),
        .retire_cnt  (retire_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       exec, step, stall, flush, halt;
        logic       fetch;
        logic [4:0] valid;
        logic [4:0] en;
        logic       ret;
        logic [2:0] st;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret_cnt = 0;

    vec_t step_tbl[10];
    vec_t run_tbl[29];

    function automatic vec_t mk(input logic e, input logic s, input logic st_r,
                                input logic fl, input logic h, input logic f,
                                input logic [4:0] v, input logic [4:0] en,
                                input logic r, input logic [2:0] st);
        vec_t x;
        x.exec = e; x.step = s; x.stall = st_r; x.flush = fl; x.halt = h;
        x.fetch = f; x.valid = v; x.en = en; x.ret = r; x.st = st;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exec = 0; step_mode = 0; stall_req = 0; flush_req = 0; halt_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset state", 32'(state), 32'd0);
        check("reset valid", 32'(stage_valid), 32'd0);
        check("reset stage_en", 32'(stage_en), 32'd0);
        check("reset fetch_en", 32'(fetch_en), 32'd0);
        check("reset retire_cnt", 32'(retire_cnt), 32'd0);
        rst_n = 1'b1;
        exp_ret_cnt = 0;
        cycle();
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        logic exp_busy;
        exec = v.exec; step_mode = v.step; stall_req = v.stall;
        flush_req = v.flush; halt_req = v.halt;
        @(negedge clk);
        exp_busy = (v.st == 3'd1) || (v.st == 3'd2) || (v.st == 3'd3);
        check($sformatf("%s[%0d] state", tag, idx), 32'(state), 32'(v.st));
        check($sformatf("%s[%0d] fetch_en", tag, idx), 32'(fetch_en), 32'(v.fetch));
        check($sformatf("%s[%0d] valid", tag, idx), 32'(stage_valid), 32'(v.valid));
        check($sformatf("%s[%0d] stage_en", tag, idx), 32'(stage_en), 32'(v.en));
        check($sformatf("%s[%0d] retire", tag, idx), 32'(retire), 32'(v.ret));
        check($sformatf("%s[%0d] busy", tag, idx), 32'(busy), 32'(exp_busy));
        check($sformatf("%s[%0d] halted", tag, idx), 32'(halted), 32'(v.st == 3'd4));
`ifdef STAGE_SEQ_PERF_EN
        check($sformatf("%s[%0d] retire_cnt", tag, idx), 32'(retire_cnt), 32'(exp_ret_cnt));
`else
        check($sformatf("%s[%0d] retire_cnt", tag, idx), 32'(retire_cnt), 32'd0);
`endif
        exp_ret_cnt += int'(v.ret);
        $display("%s cycle %0d: state=%0d fetch=%b valid=%b en=%b retire=%b",
                 tag, idx, state, fetch_en, stage_valid, stage_en, retire);
        cycle();
        exec = 0; step_mode = 0; stall_req = 0; flush_req = 0; halt_req = 0;
    endtask

    initial begin
        //                 ex st sl fl ht  fe  valid     en        rt state
        step_tbl[0] = mk(1, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 3'd0);
        step_tbl[1] = mk(0, 0, 0, 0, 0, 1, 5'b00000, 5'b11111, 0, 3'd2);
        step_tbl[2] = mk(0, 0, 0, 0, 0, 0, 5'b00001, 5'b11111, 0, 3'd3);
        step_tbl[3] = mk(1, 0, 0, 0, 0, 0, 5'b00010, 5'b11111, 0, 3'd3);
        step_tbl[4] = mk(0, 0, 0, 0, 0, 0, 5'b00100, 5'b11111, 0, 3'd3);
        step_tbl[5] = mk(0, 0, 0, 0, 0, 0, 5'b01000, 5'b11111, 0, 3'd3);
        step_tbl[6] = mk(0, 0, 0, 0, 0, 0, 5'b10000, 5'b11111, 1, 3'd3);
        step_tbl[7] = mk(0, 0, 0, 0, 0, 0, 5'b00000, 5'b11111, 0, 3'd3);
        step_tbl[8] = mk(0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 3'd0);
        step_tbl[9] = mk(0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 3'd0);

        run_tbl[0]  = mk(1, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 3'd0);
        run_tbl[1]  = mk(0, 0, 0, 0, 0, 1, 5'b00000, 5'b11111, 0, 3'd1);
        run_tbl[2]  = mk(0, 0, 0, 0, 0, 1, 5'b00001, 5'b11111, 0, 3'd1);
        run_tbl[3]  = mk(0, 0, 0, 0, 0, 1, 5'b00011, 5'b11111, 0, 3'd1);
        run_tbl[4]  = mk(0, 0, 0, 0, 0, 1, 5'b00111, 5'b11111, 0, 3'd1);
        run_tbl[5]  = mk(0, 0, 0, 0, 0, 1, 5'b01111, 5'b11111, 0, 3'd1);
        run_tbl[6]  = mk(0, 0, 0, 0, 0, 1, 5'b11111, 5'b11111, 1, 3'd1);
        run_tbl[7]  = mk(0, 0, 0, 0, 0, 1, 5'b11111, 5'b11111, 1, 3'd1);
        run_tbl[8]  = mk(0, 0, 1, 0, 0, 0, 5'b11111, 5'b11100, 1, 3'd1);
        run_tbl[9]  = mk(0, 0, 1, 0, 0, 0, 5'b11011, 5'b11100, 1, 3'd1);
        run_tbl[10] = mk(0, 0, 0, 0, 0, 1, 5'b10011, 5'b11111, 1, 3'd1);
        run_tbl[11] = mk(0, 0, 0, 0, 0, 1, 5'b00111, 5'b11111, 0, 3'd1);
        run_tbl[12] = mk(0, 0, 0, 0, 0, 1, 5'b01111, 5'b11111, 0, 3'd1);
        run_tbl[13] = mk(0, 0, 0, 0, 0, 1, 5'b11111, 5'b11111, 1, 3'd1);
        run_tbl[14] = mk(0, 0, 1, 1, 0, 0, 5'b11111, 5'b11111, 1, 3'd1);
        run_tbl[15] = mk(0, 0, 0, 0, 0, 1, 5'b11000, 5'b11111, 1, 3'd1);
        run_tbl[16] = mk(0, 0, 0, 0, 0, 1, 5'b10001, 5'b11111, 1, 3'd1);
        run_tbl[17] = mk(0, 0, 0, 0, 0, 1, 5'b00011, 5'b11111, 0, 3'd1);
        run_tbl[18] = mk(0, 0, 0, 0, 0, 1, 5'b00111, 5'b11111, 0, 3'd1);
        run_tbl[19] = mk(0, 0, 0, 0, 0, 1, 5'b01111, 5'b11111, 0, 3'd1);
        run_tbl[20] = mk(0, 0, 0, 0, 0, 1, 5'b11111, 5'b11111, 1, 3'd1);
        run_tbl[21] = mk(0, 0, 0, 0, 1, 0, 5'b11111, 5'b11111, 1, 3'd1);
        run_tbl[22] = mk(0, 0, 0, 0, 0, 0, 5'b11100, 5'b11111, 1, 3'd3);
        run_tbl[23] = mk(0, 0, 0, 0, 0, 0, 5'b11000, 5'b11111, 1, 3'd3);
        run_tbl[24] = mk(0, 0, 0, 0, 0, 0, 5'b10000, 5'b11111, 1, 3'd3);
        run_tbl[25] = mk(0, 0, 0, 0, 0, 0, 5'b00000, 5'b11111, 0, 3'd3);
        run_tbl[26] = mk(0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 3'd4);
        run_tbl[27] = mk(1, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 3'd4);
        run_tbl[28] = mk(0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 3'd4);

        do_reset();
        for (int i = 0; i < 10; i++) apply(step_tbl[i], "step", i);

        do_reset();
        for (int i = 0; i < 29; i++) apply(run_tbl[i], "run", i);
        @(negedge clk);
`ifdef STAGE_SEQ_PERF_EN
        check("run retire_cnt total", 32'(retire_cnt), 32'd14);
        check("run stall_cnt total", 32'(stall_cnt), 32'd2);
`else
        check("run stall_cnt tied", 32'(stall_cnt), 32'd0);
`endif

        // Asynchronous reset in the middle of a full pipeline.
        do_reset();
        exec = 1;
        cycle();
        exec = 0;
        repeat (7) cycle();
        check("pre-reset valid full", 32'(stage_valid), 32'h1f);
        check("pre-reset state RUN", 32'(state), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset state", 32'(state), 32'd0);
        check("async reset valid", 32'(stage_valid), 32'd0);
        check("async reset fetch_en", 32'(fetch_en), 32'd0);
        check("async reset retire", 32'(retire), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset retire_cnt", 32'(retire_cnt), 32'd0);
        check("async reset stall_cnt", 32'(stall_cnt), 32'd0);
        $display("async reset mid-RUN: state=%0d valid=%b", state, stage_valid);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

`ifdef STAGE_SEQ_PERF_EN
        // Continuous RUN: retires start at cycle 6, so the count at cycle k is k-6.
        do_reset();
        exec = 1;
        cycle();
        exec = 0;
        repeat (65540) cycle();
        @(negedge clk);
        check("retire_cnt at max", 32'(retire_cnt), 32'd65535);
        $display("wrap: cycle 65541 retire_cnt=%0d", retire_cnt);
        cycle();
        @(negedge clk);
        check("retire_cnt wrapped", 32'(retire_cnt), 32'd0);
        $display("wrap: cycle 65542 retire_cnt=%0d", retire_cnt);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
